ex_muldiv_unit: RTL and testbench
=================================

// Module: ex_muldiv_unit
// PURPOSE
//  Multi-cycle multiply/divide unit with architectural HI/LO registers, beside the EX-stage ALU.
//  Executes MULT, MULTU, DIV, DIVU iteratively and serves MFHI, MFLO, MTHI, MTLO.
//  Raises Stall so the pipeline holds any HI/LO access while an operation is in flight.
//  Generalises the single-cycle HI/LO path to any operand width and radix.
// PARAMETERS
//  WIDTH  32  operand width; HI and LO are each WIDTH bits
//  STEP   1   bits retired per iteration cycle (1, 2 or 4); must divide WIDTH
// PORTS
//  CLK     in   1      clock; all state updates on the rising edge
//  RST     in   1      synchronous, active-high reset
//  Start   in   1      request valid this cycle; Funct selects the operation
//  Funct   in   6      MIPS funct: 10 MFHI, 11 MTHI, 12 MFLO, 13 MTLO, 18 MULT, 19 MULTU, 1A DIV, 1B DIVU
//  Rdata1  in   WIDTH  rs operand: multiplicand / dividend / MTHI-MTLO data
//  Rdata2  in   WIDTH  rt operand: multiplier / divisor
//  Result  out  WIDTH  MFHI -> HI, MFLO -> LO, otherwise 0 (combinational)
//  Busy    out  1      high from the cycle after an accepted mul/div until Done
//  Done    out  1      one-cycle pulse; HI/LO hold the new result in the same cycle
//  Stall   out  1      Start & Busy (combinational); upstream holds the instruction
//  HI      out  WIDTH  HI register
//  LO      out  WIDTH  LO register
// BEHAVIOUR
//  Reset: HI=LO=0, Busy=0, Done=0, state IDLE. Reset mid-operation aborts it; no partial HI/LO write.
//  FSM: IDLE -> RUN (mul/div accepted) -> FIX -> IDLE.
//   IDLE: a Start is accepted only when Busy=0.
//   RUN: WIDTH/STEP cycles. Shift-add for multiply. Restoring division for divide, STEP quotient bits per cycle.
//   FIX: conditional two's-complement of the magnitudes, then HI/LO written. Done=1, Busy=0 on exit.
//  Latency: Start edge -> Done = WIDTH/STEP + 1 cycles (33 for WIDTH=32, STEP=1).
//  Signed ops: operate on |Rdata1|, |Rdata2| held as WIDTH+1-bit magnitudes.
//   MULT: product sign = sign1 ^ sign2.
//   DIV: quotient sign = sign1 ^ sign2; remainder sign = sign1.
//  Result mapping: multiply -> {HI,LO} = 2*WIDTH-bit product. Divide -> LO = quotient, HI = remainder.
//  Overflow: DIV of min-int by -1 gives LO = min-int, HI = 0. No trap.
//  Divide by zero: skip RUN and go straight to FIX. LO = all ones, HI = Rdata1. Done 1 cycle after Start.
//  MTHI/MTLO: with Busy=0, HI/LO takes Rdata1 at the next edge. No Busy, no Done.
//  MFHI/MFLO: Result is valid in the same cycle when Busy=0.
//  Any Start while Busy=1: Stall=1 and the request is not accepted (this includes a second mul/div).
//   Upstream re-presents it. State and operands of the running op are unaffected.
//  Done cycle: Busy=0. A new Start in that same cycle is accepted. MFHI/MFLO then read the new values.
//  Operands are captured at acceptance; Rdata1/Rdata2 are don't-care afterwards.
// STRUCTURE
//  Shared package ex_pkg: FN_MFHI..FN_DIVU funct localparams and the muldiv state encoding.
//   The ALU decoder reuses these constants.
//  Sub-module muldiv_iter: combinational STEP-bit iteration slice.
//   Add/shift for multiply, compare/subtract for divide.
//   Instanced once; the top keeps the FSM, counter, sign flags and HI/LO.
//  Iteration counter width: $clog2(WIDTH/STEP+1).
// TESTING
//  MULT 3 x -4 (FFFFFFFC) -> Done at cycle 33; HI=FFFFFFFF, LO=FFFFFFF4.
//  MULTU FFFFFFFF x FFFFFFFF -> HI=FFFFFFFE, LO=00000001.
//  DIV -7 / 2 -> LO=FFFFFFFD, HI=FFFFFFFF.
//   DIVU 100 / 7 -> LO=0000000E, HI=00000002.
//  DIVU 100 / 0 -> Done 1 cycle after Start; LO=FFFFFFFF, HI=00000064.
//   DIV 80000000 / FFFFFFFF -> LO=80000000, HI=0.
//  MFLO and MTHI issued mid-MULT -> Stall=1 each cycle; HI unchanged.
//   After Done, MTHI 5 -> HI=5; MFHI -> Result=5.
//  RST at RUN cycle 10 -> next cycle Busy=0, HI=LO=0, no Done.
//   Repeat the whole set with STEP=2 and STEP=4: same results, Done at 17 and 9 cycles.

Source files
------------

// File: rtl/ex_pkg.sv
// ex_pkg: shared EX-stage constants.
//  - MIPS funct codes for the HI/LO and multiply/divide instructions
//    (also consumed by the ALU decoder).
//  - State encoding of the iterative multiply/divide unit.
package ex_pkg;

  localparam int unsigned FUNCT_W = 6;

  // HI/LO move instructions
  localparam logic [FUNCT_W-1:0] FN_MFHI  = 6'h10;
  localparam logic [FUNCT_W-1:0] FN_MTHI  = 6'h11;
  localparam logic [FUNCT_W-1:0] FN_MFLO  = 6'h12;
  localparam logic [FUNCT_W-1:0] FN_MTLO  = 6'h13;

  // Multi-cycle arithmetic
  localparam logic [FUNCT_W-1:0] FN_MULT  = 6'h18;
  localparam logic [FUNCT_W-1:0] FN_MULTU = 6'h19;
  localparam logic [FUNCT_W-1:0] FN_DIV   = 6'h1A;
  localparam logic [FUNCT_W-1:0] FN_DIVU  = 6'h1B;

  // Multiply/divide sequencer states
  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

endpackage : ex_pkg

// File: rtl/muldiv_iter.sv
// muldiv_iter: combinational STEP-bit slice of the iterative multiply/divide.
//  Multiply (shift-add): {acc,aux} is the partial product, aux shifts the
//  multiplier out LSB first; opnd is the multiplicand magnitude.
//  Divide (restoring): acc is the partial remainder, aux shifts the dividend
//  out MSB first and collects quotient bits; opnd is the divisor magnitude.
// Ports:
//  is_div_i  select divide step (1) or multiply step (0)
//  acc_i/o   WIDTH+1-bit accumulator / partial remainder
//  aux_i/o   WIDTH-bit multiplier-shift / dividend-quotient register
//  opnd_i    WIDTH+1-bit multiplicand / divisor magnitude
module muldiv_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 1
) (
  input  logic             is_div_i,
  input  logic [WIDTH:0]   acc_i,
  input  logic [WIDTH-1:0] aux_i,
  input  logic [WIDTH:0]   opnd_i,
  output logic [WIDTH:0]   acc_o,
  output logic [WIDTH-1:0] aux_o
);

  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] aux;
  logic [WIDTH+1:0] sum;
  logic [WIDTH:0]   rem;

  // Unrolled STEP iterations of the radix-2 step
  always_comb begin
    acc = acc_i;
    aux = aux_i;
    sum = '0;
    rem = '0;
    for (int i = 0; i < int'(STEP); i++) begin
      if (!is_div_i) begin
        // Add multiplicand when the current multiplier bit is set, then
        // shift the whole {acc,aux} product right by one.
        sum = {1'b0, acc} + (aux[0] ? {1'b0, opnd_i} : (WIDTH+2)'(0));
        aux = {sum[0], aux[WIDTH-1:1]};
        acc = sum[WIDTH+1:1];
      end else begin
        // Bring in the next dividend bit; subtract divisor when it fits.
        rem = {acc[WIDTH-1:0], aux[WIDTH-1]};
        aux = {aux[WIDTH-2:0], 1'b0};
        if (rem >= opnd_i) begin
          rem    = rem - opnd_i;
          aux[0] = 1'b1;
        end
        acc = rem;
      end
    end
  end

  assign acc_o = acc;
  assign aux_o = aux;

endmodule : muldiv_iter

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative multiply/divide unit with architectural HI/LO.
//  MULT/MULTU/DIV/DIVU run WIDTH/STEP iteration cycles plus one sign-fix
//  cycle; MFHI/MFLO/MTHI/MTLO are served when the unit is not busy.
//  STEP (1, 2 or 4) must divide WIDTH.
// Ports:
//  CLK, RST        clock, synchronous active-high reset
//  Start, Funct    request valid + MIPS funct code
//  Rdata1, Rdata2  rs / rt operands, captured at acceptance
//  Result          MFHI -> HI, MFLO -> LO, else 0 (combinational)
//  Busy, Done      operation in flight / one-cycle completion pulse
//  Stall           Start & Busy (combinational)
//  HI, LO          architectural registers
module ex_muldiv_unit
  import ex_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               Start,
  input  logic [FUNCT_W-1:0] Funct,
  input  logic [WIDTH-1:0]   Rdata1,
  input  logic [WIDTH-1:0]   Rdata2,
  output logic [WIDTH-1:0]   Result,
  output logic               Busy,
  output logic               Done,
  output logic               Stall,
  output logic [WIDTH-1:0]   HI,
  output logic [WIDTH-1:0]   LO
);

  localparam int unsigned NITER = WIDTH / STEP;
  localparam int unsigned CNT_W = $clog2(NITER + 1);
  localparam int unsigned MAG_W = WIDTH + 1;
  localparam int unsigned PRD_W = 2 * WIDTH;

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [MAG_W-1:0] acc_q, acc_d;
  logic [MAG_W-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] aux_q, aux_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             is_div_q, is_div_d;
  logic             negq_q, negq_d;   // product / quotient negate
  logic             negr_q, negr_d;   // remainder negate
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Operand decode: signed ops work on WIDTH+1-bit magnitudes so that
  // |min-int| is representable.
  logic             op_signed;
  logic             sgn1, sgn2;
  logic [MAG_W-1:0] mag1, mag2;
  logic             div_by_zero;

  assign op_signed   = (Funct == FN_MULT) || (Funct == FN_DIV);
  assign sgn1        = op_signed & Rdata1[WIDTH-1];
  assign sgn2        = op_signed & Rdata2[WIDTH-1];
  assign mag1        = sgn1 ? MAG_W'(0) - {Rdata1[WIDTH-1], Rdata1} : {1'b0, Rdata1};
  assign mag2        = sgn2 ? MAG_W'(0) - {Rdata2[WIDTH-1], Rdata2} : {1'b0, Rdata2};
  assign div_by_zero = (Rdata2 == '0);

  // One iteration slice shared by multiply and divide
  logic [MAG_W-1:0] iter_acc;
  logic [WIDTH-1:0] iter_aux;

  muldiv_iter #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_iter (
    .is_div_i (is_div_q),
    .acc_i    (acc_q),
    .aux_i    (aux_q),
    .opnd_i   (opnd_q),
    .acc_o    (iter_acc),
    .aux_o    (iter_aux)
  );

  // Sign fix-up of the final magnitudes
  logic [PRD_W-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign prod     = {acc_q[WIDTH-1:0], aux_q};
  assign prod_fix = negq_q ? PRD_W'(0) - prod : prod;
  assign quo_fix  = negq_q ? WIDTH'(0) - aux_q : aux_q;
  assign rem_fix  = negr_q ? WIDTH'(0) - acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

  // State and datapath registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      aux_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      aux_q    <= aux_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    aux_d    = aux_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    unique case (state_q)
      MD_IDLE: begin
        if (Start) begin
          case (Funct)
            FN_MTHI: hi_d = Rdata1;
            FN_MTLO: lo_d = Rdata1;
            FN_MULT, FN_MULTU: begin
              state_d  = MD_RUN;
              busy_d   = 1'b1;
              cnt_d    = CNT_W'(NITER);
              is_div_d = 1'b0;
              acc_d    = '0;
              aux_d    = mag2[WIDTH-1:0];
              opnd_d   = mag1;
              negq_d   = sgn1 ^ sgn2;
              negr_d   = 1'b0;
            end
            FN_DIV, FN_DIVU: begin
              busy_d   = 1'b1;
              is_div_d = 1'b1;
              if (div_by_zero) begin
                // Preload the fixed divide-by-zero answer and skip RUN.
                state_d = MD_FIX;
                acc_d   = {1'b0, Rdata1};
                aux_d   = '1;
                opnd_d  = '0;
                negq_d  = 1'b0;
                negr_d  = 1'b0;
              end else begin
                state_d = MD_RUN;
                cnt_d   = CNT_W'(NITER);
                acc_d   = '0;
                aux_d   = mag1[WIDTH-1:0];
                opnd_d  = mag2;
                negq_d  = sgn1 ^ sgn2;
                negr_d  = sgn1;
              end
            end
            default: ;
          endcase
        end
      end

      MD_RUN: begin
        acc_d = iter_acc;
        aux_d = iter_aux;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = MD_FIX;
        end
      end

      MD_FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[PRD_W-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        state_d = MD_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end

      default: begin
        state_d = MD_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // HI/LO read port and pipeline hold
  assign Result = (Funct == FN_MFHI) ? hi_q :
                  (Funct == FN_MFLO) ? lo_q : '0;
  assign Stall  = Start & busy_q;

  assign Busy = busy_q;
  assign Done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule : ex_muldiv_unit

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: three instances (STEP = 1, 2, 4) run
// the same vector set in turn.
module tb_ex_muldiv_unit;
  import ex_pkg::*;

  localparam int unsigned W    = 32;
  localparam int unsigned NDUT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_a   [NDUT];
  logic         start_a [NDUT];
  logic [5:0]   funct_a [NDUT];
  logic [W-1:0] r1_a    [NDUT];
  logic [W-1:0] r2_a    [NDUT];
  logic [W-1:0] res_a   [NDUT];
  logic         busy_a  [NDUT];
  logic         done_a  [NDUT];
  logic         stall_a [NDUT];
  logic [W-1:0] hi_a    [NDUT];
  logic [W-1:0] lo_a    [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    ex_muldiv_unit #(
      .WIDTH (W),
      .STEP  (1 << g)
    ) u_dut (
      .CLK    (clk),
      .RST    (rst_a[g]),
      .Start  (start_a[g]),
      .Funct  (funct_a[g]),
      .Rdata1 (r1_a[g]),
      .Rdata2 (r2_a[g]),
      .Result (res_a[g]),
      .Busy   (busy_a[g]),
      .Done   (done_a[g]),
      .Stall  (stall_a[g]),
      .HI     (hi_a[g]),
      .LO     (lo_a[g])
    );
  end

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present one request for exactly one edge, then drop it and scramble operands.
  task automatic issue(input int k, input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start_a[k] = 1'b1;
    funct_a[k] = f;
    r1_a[k]    = a;
    r2_a[k]    = b;
    @(posedge clk);
    #1;
    start_a[k] = 1'b0;
    funct_a[k] = 6'h00;
    r1_a[k]    = 32'hA5A5_5A5A;
    r2_a[k]    = 32'h5A5A_A5A5;
  endtask

  // Count edges after acceptance until Done, bounded.
  task automatic wait_done(input int k, output int cyc);
    cyc = 0;
    while (!done_a[k] && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic run_op(input int k, input string name, input logic [5:0] f,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                        input int exp_lat);
    int cyc;
    issue(k, f, a, b);
    chk($sformatf("s%0d %s busy", 1 << k, name), 64'(busy_a[k]), 64'd1);
    wait_done(k, cyc);
    chk($sformatf("s%0d %s latency", 1 << k, name), 64'(cyc), 64'(exp_lat));
    chk($sformatf("s%0d %s hi", 1 << k, name), 64'(hi_a[k]), 64'(exp_hi));
    chk($sformatf("s%0d %s lo", 1 << k, name), 64'(lo_a[k]), 64'(exp_lo));
    chk($sformatf("s%0d %s busy@done", 1 << k, name), 64'(busy_a[k]), 64'd0);
    @(posedge clk);
    #1;
    chk($sformatf("s%0d %s done pulse", 1 << k, name), 64'(done_a[k]), 64'd0);
  endtask

  initial begin
    int lat;
    int cyc;
    int done_seen;

    for (int k = 0; k < int'(NDUT); k++) begin
      rst_a[k]   = 1'b1;
      start_a[k] = 1'b0;
      funct_a[k] = 6'h00;
      r1_a[k]    = '0;
      r2_a[k]    = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < int'(NDUT); k++) begin
      chk($sformatf("s%0d reset hi", 1 << k), 64'(hi_a[k]), 64'd0);
      chk($sformatf("s%0d reset lo", 1 << k), 64'(lo_a[k]), 64'd0);
      chk($sformatf("s%0d reset busy", 1 << k), 64'(busy_a[k]), 64'd0);
      chk($sformatf("s%0d reset done", 1 << k), 64'(done_a[k]), 64'd0);
    end
    @(negedge clk);
    for (int k = 0; k < int'(NDUT); k++) rst_a[k] = 1'b0;

    for (int k = 0; k < int'(NDUT); k++) begin
      lat = 32 / (1 << k) + 1;

      run_op(k, "mult 3x-4", FN_MULT, 32'd3, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFF4, lat);
      run_op(k, "multu max", FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, lat);
      run_op(k, "mult -1x-1", FN_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, lat);
      run_op(k, "div -7/2", FN_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, lat);
      run_op(k, "div 7/-2", FN_DIV, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, lat);
      run_op(k, "divu 100/7", FN_DIVU, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E, lat);
      run_op(k, "divu 100/0", FN_DIVU, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, 1);
      run_op(k, "div minint/-1", FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, lat);

      // Known HI before the stall test
      issue(k, FN_MTHI, 32'h1234_5678, 32'h0);
      chk($sformatf("s%0d mthi pre", 1 << k), 64'(hi_a[k]), 64'h1234_5678);

      // HI/LO accesses during a MULT must stall and leave HI alone
      issue(k, FN_MULT, 32'd3, 32'hFFFF_FFFC);
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        start_a[k] = 1'b1;
        funct_a[k] = (i % 2 == 0) ? FN_MFLO : FN_MTHI;
        r1_a[k]    = 32'hDEAD_BEEF;
        #1;
        chk($sformatf("s%0d stall %0d", 1 << k, i), 64'(stall_a[k]), 64'd1);
        @(posedge clk);
        #1;
        chk($sformatf("s%0d hi held %0d", 1 << k, i), 64'(hi_a[k]), 64'h1234_5678);
      end
      start_a[k] = 1'b0;
      funct_a[k] = 6'h00;
      wait_done(k, cyc);
      chk($sformatf("s%0d stalled mult done", 1 << k), 64'(done_a[k]), 64'd1);
      chk($sformatf("s%0d stalled mult hi", 1 << k), 64'(hi_a[k]), 64'hFFFF_FFFF);
      chk($sformatf("s%0d stalled mult lo", 1 << k), 64'(lo_a[k]), 64'hFFFF_FFF4);

      // MTHI then MFHI/MFLO reads
      issue(k, FN_MTHI, 32'd5, 32'h0);
      chk($sformatf("s%0d mthi hi", 1 << k), 64'(hi_a[k]), 64'd5);
      chk($sformatf("s%0d mthi busy", 1 << k), 64'(busy_a[k]), 64'd0);
      chk($sformatf("s%0d mthi done", 1 << k), 64'(done_a[k]), 64'd0);
      @(negedge clk);
      start_a[k] = 1'b1;
      funct_a[k] = FN_MFHI;
      #1;
      chk($sformatf("s%0d mfhi", 1 << k), 64'(res_a[k]), 64'd5);
      chk($sformatf("s%0d mfhi stall", 1 << k), 64'(stall_a[k]), 64'd0);
      funct_a[k] = FN_MFLO;
      #1;
      chk($sformatf("s%0d mflo", 1 << k), 64'(res_a[k]), 64'hFFFF_FFF4);
      start_a[k] = 1'b0;
      funct_a[k] = 6'h00;
      #1;
      chk($sformatf("s%0d result idle", 1 << k), 64'(res_a[k]), 64'd0);

      // Reset in the middle of RUN aborts without touching HI/LO afterwards
      issue(k, FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      repeat ((lat - 1) / 2) @(posedge clk);
      @(negedge clk);
      rst_a[k] = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("s%0d rst busy", 1 << k), 64'(busy_a[k]), 64'd0);
      chk($sformatf("s%0d rst hi", 1 << k), 64'(hi_a[k]), 64'd0);
      chk($sformatf("s%0d rst lo", 1 << k), 64'(lo_a[k]), 64'd0);
      chk($sformatf("s%0d rst done", 1 << k), 64'(done_a[k]), 64'd0);
      @(negedge clk);
      rst_a[k] = 1'b0;
      done_seen = 0;
      repeat (40) begin
        @(posedge clk);
        #1;
        if (done_a[k]) done_seen++;
      end
      chk($sformatf("s%0d no done after rst", 1 << k), 64'(done_seen), 64'd0);
      chk($sformatf("s%0d hi after rst", 1 << k), 64'(hi_a[k]), 64'd0);

      run_op(k, "divu after rst", FN_DIVU, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E, lat);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_ex_muldiv_unit
